// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared types and constants for the branch-predictor update
//                scheduler: default tag width, queued-update record, port-op
//                encoding and scheduler state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // Default branch tag width (PC index bits)
  localparam int BP_TAG_LEN = 10;

  // Predictor port operation encoding carried on pred_we
  localparam logic BP_OP_READ  = 1'b0;
  localparam logic BP_OP_WRITE = 1'b1;

  // One resolved-branch update as held in the update FIFO
  typedef struct packed {
    logic [BP_TAG_LEN-1:0] tag;
    logic                  taken;
  } bp_upd_t;

  // Scheduler state: normal arbitration, or one forced drain pending
  typedef enum logic [0:0] {
    SCHED_NORMAL = 1'b0,
    SCHED_FORCE  = 1'b1
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/bp_update_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : bp_update_sched_if
//  Description : Bundle of the update sources, fetch lookup, flush and the
//                predictor-side port of the update scheduler. The scheduler
//                uses the slave view; its environment uses the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bp_update_sched_if
  import bp_pkg::*;
#(
  parameter int TAG_LEN = BP_TAG_LEN,
  parameter int DEPTH   = 4
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               flush;

  logic               upd0_valid;
  logic               upd0_ready;
  logic [TAG_LEN-1:0] upd0_tag;
  logic               upd0_taken;

  logic               upd1_valid;
  logic               upd1_ready;
  logic [TAG_LEN-1:0] upd1_tag;
  logic               upd1_taken;

  logic               lkp_valid;
  logic               lkp_ready;
  logic [TAG_LEN-1:0] lkp_tag;

  logic               pred_en;
  logic               pred_we;
  logic [TAG_LEN-1:0] pred_tag;
  logic               pred_taken;

  logic [CNT_W-1:0]   q_count;

  // Environment side: IF/EX stages and the predictor table
  modport master (
    output flush,
    output upd0_valid, upd0_tag, upd0_taken,
    output upd1_valid, upd1_tag, upd1_taken,
    output lkp_valid, lkp_tag,
    input  upd0_ready, upd1_ready, lkp_ready,
    input  pred_en, pred_we, pred_tag, pred_taken,
    input  q_count
  );

  // Scheduler side
  modport slave (
    input  flush,
    input  upd0_valid, upd0_tag, upd0_taken,
    input  upd1_valid, upd1_tag, upd1_taken,
    input  lkp_valid, lkp_tag,
    output upd0_ready, upd1_ready, lkp_ready,
    output pred_en, pred_we, pred_tag, pred_taken,
    output q_count
  );

endinterface
`default_nettype wire

// File: rtl/bp_upd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bp_upd_fifo
//  Description : Small synchronous FIFO holding queued predictor updates.
//                Power-of-two depth so pointers wrap naturally. Full/empty
//                come from the registered count. flush empties the FIFO at
//                the clock edge and blocks both read and write that cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = BP_TAG_LEN + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_wr;
  logic             do_rd;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_wr   = wr_en & ~full & ~flush;
  assign do_rd   = rd_en & ~empty & ~flush;
  assign rd_data = mem[rd_ptr];
  assign count   = cnt;

  // Pointer and occupancy tracking; simultaneous push and pop hold the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/bp_update_sched.sv
`default_nettype none
// ============================================================================
//  Module      : bp_update_sched
//  Description : Scheduler for the branch predictor's single table port.
//                Two resolved-branch sources are merged round-robin into a
//                small FIFO; queued updates drain when no fetch lookup is
//                pending, and a starvation guard forces one drain after
//                STARVE_LIM consecutive lookup wins over a non-empty FIFO.
//  Options     : BP_SCHED_STATS_EN adds force_cnt / stall_cnt outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_update_sched
  import bp_pkg::*;
#(
  parameter int TAG_LEN    = BP_TAG_LEN,
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  bp_update_sched_if.slave  bus
`ifdef BP_SCHED_STATS_EN
  ,
  output logic [15:0]       force_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int                 CNT_W    = $clog2(DEPTH) + 1;
  localparam int                 WAIT_W   = $clog2(STARVE_LIM + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LIM = WAIT_W'(STARVE_LIM);

  sched_state_t       state;
  sched_state_t       state_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [WAIT_W-1:0]  wait_nxt;
  logic               rr_ptr;

  logic               grant0;
  logic               grant1;
  logic               ready0;
  logic               ready1;
  logic               enq;
  logic [TAG_LEN:0]   enq_data;

  logic               lkp_win;
  logic               deq;
  logic [TAG_LEN:0]   head;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;

  // Round-robin grant between the two update sources and FIFO write select
  always_comb begin
    grant0   = bus.upd0_valid & (~bus.upd1_valid | ~rr_ptr);
    grant1   = bus.upd1_valid & (~bus.upd0_valid |  rr_ptr);
    ready0   = grant0 & ~full & ~bus.flush;
    ready1   = grant1 & ~full & ~bus.flush;
    enq      = ready0 | ready1;
    enq_data = ready1 ? {bus.upd1_tag, bus.upd1_taken}
                      : {bus.upd0_tag, bus.upd0_taken};
  end

  // Port ownership: lookups win unless a forced drain is due; a flush cycle
  // still serves lookups but never writes the predictor
  always_comb begin
    lkp_win = bus.lkp_valid & ((state == SCHED_NORMAL) | bus.flush);
    deq     = ~lkp_win & ~empty & ~bus.flush;
  end

  // Round-robin pointer moves only when an update is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (enq) begin
      rr_ptr <= ready0;
    end
  end

  // Starvation guard state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SCHED_NORMAL;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Starvation guard next state: count lookup wins over a waiting FIFO and
  // arm a forced drain when the limit is reached
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    if (bus.flush || deq || empty) begin
      state_nxt = SCHED_NORMAL;
      wait_nxt  = '0;
    end else if (lkp_win && (wait_cnt != WAIT_LIM)) begin
      wait_nxt = wait_cnt + 1'b1;
      if (wait_cnt == WAIT_LIM - 1'b1) begin
        state_nxt = SCHED_FORCE;
      end
    end
  end

  // Predictor port mux; every output is held low while reset is asserted
  always_comb begin
    bus.pred_en    = 1'b0;
    bus.pred_we    = BP_OP_READ;
    bus.pred_tag   = '0;
    bus.pred_taken = 1'b0;
    bus.lkp_ready  = 1'b0;
    if (!rst) begin
      if (lkp_win) begin
        bus.pred_en   = 1'b1;
        bus.pred_we   = BP_OP_READ;
        bus.pred_tag  = bus.lkp_tag;
        bus.lkp_ready = 1'b1;
      end else if (deq) begin
        bus.pred_en    = 1'b1;
        bus.pred_we    = BP_OP_WRITE;
        bus.pred_tag   = head[TAG_LEN:1];
        bus.pred_taken = head[0];
      end
    end
  end

  assign bus.upd0_ready = ready0 & ~rst;
  assign bus.upd1_ready = ready1 & ~rst;
  assign bus.q_count    = count;

  bp_upd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TAG_LEN + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.flush),
    .wr_en   (enq),
    .wr_data (enq_data),
    .rd_en   (deq),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

`ifdef BP_SCHED_STATS_EN
  logic [1:0]  stall_inc;
  logic [16:0] stall_sum;

  // Per-cycle stall contribution from both sources, widened for saturation
  always_comb begin
    stall_inc = {1'b0, bus.upd0_valid & ~ready0} + {1'b0, bus.upd1_valid & ~ready1};
    stall_sum = {1'b0, stall_cnt} + {15'b0, stall_inc};
  end

  // Saturating statistics; cleared by reset only, unaffected by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      force_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (deq && (state == SCHED_FORCE) && (force_cnt != 16'hFFFF)) begin
        force_cnt <= force_cnt + 16'd1;
      end
      stall_cnt <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_update_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_update_sched
//  Description : Self-checking bench for bp_update_sched. Scenario tasks check
//                handshakes, occupancy and port ownership cycle by cycle; a
//                scoreboard records accepted updates and checks every
//                predictor write for content and order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_update_sched;
  import bp_pkg::*;

  localparam int TAG_LEN    = BP_TAG_LEN;
  localparam int DEPTH      = 4;
  localparam int STARVE_LIM = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bp_upd_t sb[$];

  bp_update_sched_if #(.TAG_LEN(TAG_LEN), .DEPTH(DEPTH)) bus ();

`ifdef BP_SCHED_STATS_EN
  logic [15:0] force_cnt;
  logic [15:0] stall_cnt;
`endif

  bp_update_sched #(
    .TAG_LEN    (TAG_LEN),
    .DEPTH      (DEPTH),
    .STARVE_LIM (STARVE_LIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BP_SCHED_STATS_EN
    ,
    .force_cnt (force_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Handshake/port snapshot: {upd0_ready, upd1_ready, lkp_ready, pred_en, pred_we}
  logic [4:0] ctl;
  assign ctl = {bus.upd0_ready, bus.upd1_ready, bus.lkp_ready, bus.pred_en, bus.pred_we};

  // Scoreboard: record accepted updates, check each predictor write in order
  always @(negedge clk) begin
    bp_upd_t e;
    if (rst || bus.flush) begin
      sb.delete();
    end else begin
      if (bus.pred_en && bus.pred_we) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_write got tag=%h taken=%b exp none", bus.pred_tag, bus.pred_taken);
        end else begin
          e = sb.pop_front();
          if (bus.pred_tag !== e.tag || bus.pred_taken !== e.taken) begin
            errors++;
            $display("FAIL sb_write got tag=%h taken=%b exp tag=%h taken=%b",
                     bus.pred_tag, bus.pred_taken, e.tag, e.taken);
          end
        end
      end
      if (bus.upd0_valid && bus.upd0_ready) begin
        e.tag = bus.upd0_tag; e.taken = bus.upd0_taken; sb.push_back(e);
      end
      if (bus.upd1_valid && bus.upd1_ready) begin
        e.tag = bus.upd1_tag; e.taken = bus.upd1_taken; sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.flush = 1'b0;
    bus.upd0_valid = 1'b0; bus.upd0_tag = '0; bus.upd0_taken = 1'b0;
    bus.upd1_valid = 1'b0; bus.upd1_tag = '0; bus.upd1_taken = 1'b0;
    bus.lkp_valid  = 1'b0; bus.lkp_tag  = '0;
  endtask

  task automatic test_reset();
    idle();
    bus.lkp_valid = 1'b1; bus.upd0_valid = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if ({ctl, bus.q_count, bus.pred_tag, bus.pred_taken} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ctl=%b q=%0d tag=%h exp all zero", ctl, bus.q_count, bus.pred_tag);
    end
    idle();
    #1 rst = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (ctl !== 5'b00000 || bus.q_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle got ctl=%b q=%0d exp ctl=00000 q=0", ctl, bus.q_count);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_ctl;
    bus.lkp_valid = 1'b1; bus.upd0_valid = 1'b1; bus.upd1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.upd0_tag = 10'(256 + k); bus.upd0_taken = ~k[1];
      bus.upd1_tag = 10'(512 + k); bus.upd1_taken = k[0];
      bus.lkp_tag  = 10'(80 + k);
      @(negedge clk);
      // Cycle 4: FIFO full and the starvation guard forces a drain
      exp_ctl = (k < 4) ? {(k % 2 == 0), (k % 2 == 1), 3'b110} : 5'b00011;
      checks++;
      if (ctl !== exp_ctl || bus.q_count !== 3'(k)) begin
        errors++;
        $display("FAIL rr_cycle%0d got ctl=%b q=%0d exp ctl=%b q=%0d", k, ctl, bus.q_count, exp_ctl, k);
      end
      if (k < 4) begin
        checks++;
        if (bus.pred_tag !== 10'(80 + k)) begin
          errors++;
          $display("FAIL rr_lookup_tag%0d got %h exp %h", k, bus.pred_tag, 10'(80 + k));
        end
      end
      tick();
    end
    idle();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      exp_ctl = (j < 3) ? 5'b00011 : 5'b00000;
      checks++;
      if (ctl !== exp_ctl || bus.q_count !== 3'(3 - j)) begin
        errors++;
        $display("FAIL rr_drain%0d got ctl=%b q=%0d exp ctl=%b q=%0d", j, ctl, bus.q_count, exp_ctl, 3 - j);
      end
      tick();
    end
  endtask

  task automatic test_single();
    bus.upd0_valid = 1'b1; bus.upd0_tag = 10'h02A; bus.upd0_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== 5'b10000 || bus.q_count !== 3'd0) begin
      errors++;
      $display("FAIL single_accept got ctl=%b q=%0d exp ctl=10000 q=0", ctl, bus.q_count);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (ctl !== 5'b00011 || bus.pred_tag !== 10'h02A || bus.pred_taken !== 1'b1 || bus.q_count !== 3'd1) begin
      errors++;
      $display("FAIL single_drain got ctl=%b tag=%h taken=%b q=%0d exp ctl=00011 tag=02a taken=1 q=1",
               ctl, bus.pred_tag, bus.pred_taken, bus.q_count);
    end
    tick();
    @(negedge clk);
    checks++;
    if (ctl !== 5'b00000 || bus.q_count !== 3'd0) begin
      errors++;
      $display("FAIL single_empty got ctl=%b q=%0d exp ctl=00000 q=0", ctl, bus.q_count);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic [4:0] exp_ctl;
    logic [2:0] exp_q;
    bus.lkp_valid = 1'b1; bus.lkp_tag = 10'h3F0;
    bus.upd0_valid = 1'b1; bus.upd0_tag = 10'h0A1; bus.upd0_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== 5'b10110) begin
      errors++;
      $display("FAIL starve_fill0 got ctl=%b exp 10110", ctl);
    end
    tick();
    bus.upd0_valid = 1'b0;
    bus.upd1_valid = 1'b1; bus.upd1_tag = 10'h0B2; bus.upd1_taken = 1'b0;
    bus.lkp_tag = 10'h3F1;
    @(negedge clk);
    checks++;
    if (ctl !== 5'b01110 || bus.q_count !== 3'd1) begin
      errors++;
      $display("FAIL starve_fill1 got ctl=%b q=%0d exp ctl=01110 q=1", ctl, bus.q_count);
    end
    tick();
    bus.upd1_valid = 1'b0;
    // Two more lookup wins, then one forced drain, then lookups resume
    for (int j = 0; j < 4; j++) begin
      bus.lkp_tag = 10'(1010 + j);
      @(negedge clk);
      exp_ctl = (j == 2) ? 5'b00011 : 5'b00110;
      exp_q   = (j == 3) ? 3'd1 : 3'd2;
      checks++;
      if (ctl !== exp_ctl || bus.q_count !== exp_q) begin
        errors++;
        $display("FAIL starve_cycle%0d got ctl=%b q=%0d exp ctl=%b q=%0d", j, ctl, bus.q_count, exp_ctl, exp_q);
      end
      tick();
    end
    idle();
    @(negedge clk);
    checks++;
    if (ctl !== 5'b00011 || bus.q_count !== 3'd1) begin
      errors++;
      $display("FAIL starve_tail got ctl=%b q=%0d exp ctl=00011 q=1", ctl, bus.q_count);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.q_count !== 3'd0) begin
      errors++;
      $display("FAIL starve_empty got q=%0d exp 0", bus.q_count);
    end
    tick();
  endtask

  task automatic test_full_boundary();
    logic [4:0] exp_ctl;
    logic [2:0] exp_q;
    bus.upd0_valid = 1'b1; bus.upd1_valid = 1'b1;
    for (int k = 0; k < 11; k++) begin
      bus.lkp_valid  = (k < 4);
      bus.lkp_tag    = 10'(k);
      bus.upd0_tag   = 10'(320 + k); bus.upd0_taken = k[0];
      bus.upd1_tag   = 10'(384 + k); bus.upd1_taken = ~k[0];
      @(negedge clk);
      if (k < 4) begin
        exp_ctl = {(k % 2 == 0), (k % 2 == 1), 3'b110}; exp_q = 3'(k);
      end else if (k == 4) begin
        exp_ctl = 5'b00011; exp_q = 3'd4;
      end else begin
        exp_ctl = {((k - 5) % 2 == 0), ((k - 5) % 2 == 1), 3'b011}; exp_q = 3'd3;
      end
      checks++;
      if (ctl !== exp_ctl || bus.q_count !== exp_q) begin
        errors++;
        $display("FAIL full_cycle%0d got ctl=%b q=%0d exp ctl=%b q=%0d", k, ctl, bus.q_count, exp_ctl, exp_q);
      end
      tick();
    end
    idle();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      exp_ctl = (j < 3) ? 5'b00011 : 5'b00000;
      checks++;
      if (ctl !== exp_ctl || bus.q_count !== 3'(3 - j)) begin
        errors++;
        $display("FAIL full_drain%0d got ctl=%b q=%0d exp ctl=%b q=%0d", j, ctl, bus.q_count, exp_ctl, 3 - j);
      end
      tick();
    end
  endtask

  task automatic fill_three();
    bus.lkp_valid = 1'b1; bus.upd0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.upd0_tag = 10'(704 + k); bus.upd0_taken = k[0];
      bus.lkp_tag  = 10'(k);
      @(negedge clk);
      checks++;
      if (ctl !== 5'b10110 || bus.q_count !== 3'(k)) begin
        errors++;
        $display("FAIL fill%0d got ctl=%b q=%0d exp ctl=10110 q=%0d", k, ctl, bus.q_count, k);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    fill_three();
    bus.flush = 1'b1; bus.upd0_tag = 10'h2FF; bus.lkp_tag = 10'h155;
    @(negedge clk);
    checks++;
    if (ctl !== 5'b00110 || bus.pred_tag !== 10'h155 || bus.q_count !== 3'd3) begin
      errors++;
      $display("FAIL flush_cycle got ctl=%b tag=%h q=%0d exp ctl=00110 tag=155 q=3", ctl, bus.pred_tag, bus.q_count);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (ctl !== 5'b00000 || bus.q_count !== 3'd0) begin
      errors++;
      $display("FAIL flush_after got ctl=%b q=%0d exp ctl=00000 q=0", ctl, bus.q_count);
    end
    tick();
  endtask

  task automatic test_async_reset();
    fill_three();
    idle();
    @(negedge clk);
    checks++;
    if (ctl !== 5'b00011 || bus.q_count !== 3'd3) begin
      errors++;
      $display("FAIL arst_drain got ctl=%b q=%0d exp ctl=00011 q=3", ctl, bus.q_count);
    end
    tick();
    #2;
    rst = 1'b1; bus.lkp_valid = 1'b1; bus.upd0_valid = 1'b1;
    #1;
    checks++;
    if ({ctl, bus.q_count, bus.pred_tag, bus.pred_taken} !== '0) begin
      errors++;
      $display("FAIL arst_outputs got ctl=%b q=%0d tag=%h exp all zero", ctl, bus.q_count, bus.pred_tag);
    end
    idle();
    @(posedge clk);
    #3 rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      checks++;
      if (ctl !== 5'b00000 || bus.q_count !== 3'd0) begin
        errors++;
        $display("FAIL arst_quiet%0d got ctl=%b q=%0d exp ctl=00000 q=0", j, ctl, bus.q_count);
      end
      tick();
    end
    bus.upd1_valid = 1'b1; bus.upd1_tag = 10'h3A5; bus.upd1_taken = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== 5'b01000) begin
      errors++;
      $display("FAIL arst_new_accept got ctl=%b exp 01000", ctl);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (ctl !== 5'b00011 || bus.pred_tag !== 10'h3A5 || bus.q_count !== 3'd1) begin
      errors++;
      $display("FAIL arst_new_drain got ctl=%b tag=%h q=%0d exp ctl=00011 tag=3a5 q=1", ctl, bus.pred_tag, bus.q_count);
    end
    tick();
    @(negedge clk);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_starvation();
    test_full_boundary();
    test_flush();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d entries exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bp_update_sched.md
Name: bp_update_sched

Overview:
- Scheduler for the branch predictor's single table port. That port is shared between fetch-side lookups and resolved-branch updates.
- Two execute-stage update sources are merged round-robin into a small FIFO.
- Queued updates drain into the predictor when no lookup is pending. A starvation guard forces a drain if lookups hog the port.
- Sits between IF/EX and the predictor; the predictor sees one request per cycle, tagged read or write.

Parameters:
- TAG_LEN, 10, branch tag width (PC index bits).
- DEPTH, 4, update FIFO entries; power of two, at least 2.
- STARVE_LIM, 3, maximum consecutive cycles a non-empty FIFO may be blocked by lookups.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous drop of all queued updates
- upd0_valid  in  1  source 0 update valid
- upd0_ready  out  1  source 0 accepted this cycle
- upd0_tag  in  TAG_LEN  source 0 branch tag
- upd0_taken  in  1  source 0 resolved direction
- upd1_valid / upd1_ready / upd1_tag / upd1_taken  same as source 0, for source 1
- lkp_valid  in  1  fetch lookup request
- lkp_ready  out  1  lookup granted the port this cycle
- lkp_tag  in  TAG_LEN  lookup tag
- pred_en  out  1  predictor port active
- pred_we  out  1  1 = update, 0 = lookup
- pred_tag  out  TAG_LEN  tag to predictor
- pred_taken  out  1  update direction; 0 when pred_we=0
- q_count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset:
  - FIFO empty (rd/wr pointers and count = 0); rr_ptr = 0 (source 0 favoured); wait_cnt = 0; force = 0.
  - All outputs 0 while rst is high.
- Enqueue, at most one per cycle:
  - grant = the single valid source; if both are valid, the source selected by rr_ptr.
  - updN_ready = grantN & ~full & ~flush. full is derived from the registered count, so no enqueue happens when full even if a dequeue occurs that same cycle.
  - On accept: write {tag, taken} at wr_ptr, advance wr_ptr (wraps mod DEPTH), set rr_ptr to the other source.
  - rr_ptr changes only on an accept.
- Port arbitration (combinational from registered state):
  - If lkp_valid & ~force: pred_en=1, pred_we=0, pred_tag=lkp_tag, lkp_ready=1.
  - Else if FIFO not empty: pred_en=1, pred_we=1, pred_tag/pred_taken = head entry; dequeue (advance rd_ptr); lkp_ready=0.
  - Else: pred_en=0, lkp_ready=0.
- Latency:
  - Lookup: granted the same cycle.
  - Update: earliest drain is the cycle after acceptance. Acceptance into an empty FIFO drains in the next cycle if no lookup is pending.
- Count: same-cycle enqueue and dequeue leave count unchanged; otherwise count moves ±1.
- Starvation guard:
  - wait_cnt increments each cycle a lookup wins while the FIFO is non-empty.
  - Clears on any dequeue or when the FIFO is empty.
  - When wait_cnt reaches STARVE_LIM, force=1 from the next cycle. Exactly one update then drains, lkp_ready=0, and force and wait_cnt clear.
- flush:
  - Clears pointers, count, wait_cnt and force at the clock edge.
  - During the flush cycle: no enqueue, and no dequeue on the port (pred_we=0). Lookups are still served.
- Async rst mid-operation discards the FIFO contents; no partial write is emitted afterwards.

Optional Feature:
- BP_SCHED_STATS_EN:
  - Defined: adds outputs force_cnt[15:0] (forced drains) and stall_cnt[15:0] (cycles with updN_valid & ~updN_ready, summed over both sources). Both saturate at 16'hFFFF, reset to 0, are cleared by rst only, and are held through flush.
  - Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package bp_pkg:
  - TAG_LEN default constant.
  - bp_upd_t struct {tag, taken}.
  - Port-op encoding constants BP_OP_READ = 0, BP_OP_WRITE = 1.
- One sub-module: bp_upd_fifo (parameterised DEPTH, width = TAG_LEN+1, count output, flush input).
- Round-robin arbitration, starvation guard and port mux stay in the top.

Test Plan:
- Single update, no lookups: upd0 tag=0x2A taken=1 at cycle 0 → upd0_ready=1 at cycle 0; at cycle 1 pred_we=1, pred_tag=0x2A, pred_taken=1; q_count returns to 0.
- Round-robin: both sources valid for 4 cycles, lkp_valid=1 throughout → accepts alternate 0,1,0,1; q_count reaches 4; upd0_ready=upd1_ready=0 when full.
- Starvation: FIFO holds 2 entries, lkp_valid held high, STARVE_LIM=3 → lookups granted 3 cycles; 4th cycle lkp_ready=0 and the head update drains; the next lookup is granted in the following cycle.
- Full boundary: DEPTH=4 full, lkp_valid=0, both sources valid → the cycle that dequeues still shows ready=0; an enqueue resumes the next cycle; FIFO order is preserved across pointer wrap.
- Flush: 3 entries queued, flush=1 for one cycle with upd0_valid=1 → no accept, no pred_we; q_count=0 next cycle; lookup served during flush.
- Async reset mid-drain: rst pulsed between edges → all outputs 0 immediately; after release pred_en=0 until new traffic arrives.
